// File: rtl/freq_tone_gen_if.sv
// Digit request handshake between a controller and freq_tone_gen.
interface freq_tone_gen_if;
    logic [3:0] digit_i;
    logic       digit_valid_i;
    logic       digit_ready_o;

    modport master (output digit_i, output digit_valid_i, input digit_ready_o);
    modport slave  (input digit_i, input digit_valid_i, output digit_ready_o);
endinterface

// File: rtl/freq_tone_gen.sv
// Square-wave tone generator: DEPTH-cycle windows carry exactly step(digit) toggles.
// Optional seven-segment readout of the active digit when FREQ_TONE_GEN_SEG_EN is defined.
module freq_tone_gen #(
    parameter int DEPTH = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    freq_tone_gen_if.slave             dig,
    output logic                       sig_o,
    output logic                       win_done_o,
    output logic [$clog2(DEPTH+1)-1:0] toggles_o,
    output logic [3:0]                 active_digit_o
`ifdef FREQ_TONE_GEN_SEG_EN
    ,
    output logic [6:0]                 segments_o
`endif
);
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(DEPTH);
    localparam int TW = $clog2(DEPTH + 1);
    localparam int SW = AW + 1;

    // step(d) = ceil(DEPTH*(2d+1)/20), the centre of each digit's bin
    function automatic logic [9:0][AW-1:0] build_steps();
        for (int d = 0; d < 10; d++) begin
            build_steps[d] = AW'((DEPTH * (2 * d + 1) + 19) / 20);
        end
    endfunction

    localparam logic [9:0][AW-1:0] STEP_TAB = build_steps();

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

`ifdef FREQ_TONE_GEN_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q;
    logic [WW-1:0]   win_cnt_q;
    logic [TW-1:0]   tally_q;
    logic            ready;
    logic            win_end;
    logic [AW-1:0]   step_cur;
    logic [SW-1:0]   sum;
    logic            wrap;
    logic [AW-1:0]   acc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        win_end = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (dig.digit_valid_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                win_end = (win_cnt_q == WW'(DEPTH - 1));
                ready   = win_end;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dig.digit_ready_o = ready;
    assign win_done_o        = win_end;

    // Bresenham accumulator: a wrap past DEPTH is one toggle
    always_comb begin
        step_cur = STEP_TAB[active_digit_o];
        sum      = SW'(acc_q) + SW'(step_cur);
        wrap     = (sum >= SW'(DEPTH));
        acc_next = wrap ? AW'(sum - SW'(DEPTH)) : AW'(sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q          <= '0;
            win_cnt_q      <= '0;
            tally_q        <= '0;
            sig_o          <= 1'b0;
            toggles_o      <= '0;
            active_digit_o <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dig.digit_valid_i) begin
                        active_digit_o <= sat_digit(dig.digit_i);
                        acc_q          <= '0;
                        win_cnt_q      <= '0;
                        tally_q        <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    if (wrap) begin
                        sig_o <= ~sig_o;
                    end
                    if (win_end) begin
                        // report includes a toggle landing on the last cycle
                        win_cnt_q <= '0;
                        toggles_o <= tally_q + TW'(wrap);
                        tally_q   <= '0;
                        if (dig.digit_valid_i) begin
                            active_digit_o <= sat_digit(dig.digit_i);
                        end
                    end else begin
                        win_cnt_q <= win_cnt_q + WW'(1);
                        tally_q   <= tally_q + TW'(wrap);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_TONE_GEN_SEG_EN
    always_comb begin
        segments_o = (state_q == IDLE) ? 7'h00 : seg7(active_digit_o);
    end
`endif
endmodule

// File: doc/freq_tone_gen.md
Name: freq_tone_gen

Overview:
- Stimulus-side counterpart of the frequency counter: takes a decimal digit 0-9 and emits a square wave whose toggle density over a DEPTH-cycle window falls in the centre of that digit's measurement bin.
- Feeding sig_o into the counter's sig input must display the same digit.
- Uses a phase accumulator (Bresenham style) and a window counter. New digits are accepted through a valid/ready handshake, and only at window boundaries.

Parameters:
DEPTH, 1000, window length in clk cycles. It must match the counter's moving-average depth. Minimum value is 20.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
digit_i  input  4  requested digit; values above 9 are clamped to 9
digit_valid_i  input  1  digit_i is presented this cycle
digit_ready_o  output  1  generator will accept digit_i this cycle
sig_o  output  1  generated square wave
win_done_o  output  1  one-cycle pulse on the last cycle of each RUN window
toggles_o  output  $clog2(DEPTH+1)  number of sig_o toggles in the last completed window
active_digit_o  output  4  digit currently being generated

Behaviour:
- Reset (reset=0, takes effect asynchronously) clears the following:
  - state=IDLE, acc=0, win_cnt=0, sig_o=0
  - toggles_o=0, active_digit_o=0, win_done_o=0
  - internal toggle tally=0
- Step value: step(d)=ceil(DEPTH*(2d+1)/20), computed at elaboration time as a 10-entry constant table.
  - DEPTH=1000 gives 50,150,...,950.
  - DEPTH=20 gives 2d+1.
- acc width is $clog2(DEPTH)+1 and win_cnt width is $clog2(DEPTH). Compare against DEPTH without truncation.
- State IDLE:
  - sig_o holds its value; acc and win_cnt stay at 0; digit_ready_o=1.
  - When digit_valid_i=1: active_digit_o<=min(digit_i,9), acc<=0, win_cnt<=0, tally<=0, then go to RUN.
- State RUN, every cycle:
  - sum=acc+step(active_digit_o).
  - If sum>=DEPTH: acc<=sum-DEPTH, sig_o<=~sig_o, tally+1. Otherwise acc<=sum.
  - win_cnt increments.
- Window end (RUN and win_cnt==DEPTH-1):
  - win_cnt<=0 and win_done_o=1 in this same cycle (combinational from the registered count).
  - Next cycle: toggles_o holds the final tally of the window, including any toggle in the last cycle. The tally restarts at 0.
  - acc is 0 at every window end by construction, so each window contains exactly step(d) toggles.
- Handshake in RUN:
  - digit_ready_o=1 only on the window-end cycle.
  - Transfer occurs when digit_valid_i & digit_ready_o. active_digit_o updates, and the new step applies from the first cycle of the next window.
  - A valid held mid-window is simply waited on; no data is lost while valid stays high.
- Same-digit reload: accepted like any other digit; the output waveform is unchanged.
- Latency: the first toggle occurs ceil(DEPTH/step) cycles after the RUN entry edge.
- Reset asserted mid-window: sig_o is forced to 0 immediately and the block returns to IDLE. No partial window is reported on toggles_o.
- There is no path back to IDLE except reset.

Optional Feature:
FREQ_TONE_GEN_SEG_EN
- When defined: adds output segments_o[6:0]. It drives the team's standard seg7 encoding of active_digit_o and shows blank (all 0) in IDLE. This lets the board display the set digit beside the counter's measured digit.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=20, reset low for 3 cycles, then high → sig_o=0, digit_ready_o=1, toggles_o=0. sig_o also stays 0 for 50 idle cycles.
- DEPTH=20, send digit 0 → exactly 1 toggle per window; toggles_o=1 after each win_done_o pulse; first toggle 20 cycles after RUN entry.
- DEPTH=1000, digit 9 → toggles_o=950 every window. sig_o looped to the freq counter reads digit 9 after 2 windows. Repeat for digit 4 → toggles_o=450, counter shows 4.
- DEPTH=20, running digit 2; assert valid with digit 7 at win_cnt=5 → ready stays low until win_cnt=19. Window in progress reports 5 toggles; next window reports 15.
- DEPTH=20, digit_i=12 → active_digit_o=9, toggles_o=19. Then reset mid-window at win_cnt=10 → all outputs 0 immediately; toggles_o not updated.
- FREQ_TONE_GEN_SEG_EN defined, digit 3 → segments_o equals the seg7 code for 3; in IDLE after reset, segments_o=0.
